// File: rtl/quad_encoder_gen.sv
// Quadrature encoder stimulus generator: emits one Gray-code transition per
// accepted request, optionally with contact bounce, and tracks position.
module quad_encoder_gen #(
    parameter int PHASE_CYCLES  = 16,
    parameter int BOUNCE_EDGES  = 3,
    parameter int BOUNCE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_valid,
    input  logic       step_dir,
    input  logic       bounce_en,
    output logic       step_ready,
    output logic       busy,
    output logic       done,
    output logic       enc_a,
    output logic       enc_b,
    output logic [7:0] position
);

    localparam int CNT_MAX = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TOG_MAX = (2 * BOUNCE_EDGES > 1) ? 2 * BOUNCE_EDGES : 1;
    localparam int TOG_W   = $clog2(TOG_MAX + 1);

    localparam logic             BOUNCE_ON   = (BOUNCE_EDGES > 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [TOG_W-1:0] TOG_INIT    = TOG_W'(2 * BOUNCE_EDGES);

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    // mask marks the moving line so bounce is a plain XOR
    typedef struct packed {
        logic       dir;
        logic [1:0] mask;
    } xfer_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [TOG_W-1:0] tog, tog_n;
    logic [1:0]       ab, ab_n, tgt;
    xfer_t            xfer, xfer_n;
    logic [7:0]       pos, pos_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tog    <= '0;
            ab     <= 2'b00;
            xfer   <= '0;
            pos    <= 8'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tog    <= tog_n;
            ab     <= ab_n;
            xfer   <= xfer_n;
            pos    <= pos_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tog_n   = tog;
        ab_n    = ab;
        xfer_n  = xfer;
        pos_n   = pos;
        done_n  = 1'b0;
        // ab = {a,b}; CW maps {a,b}->{~b,a}, CCW maps {a,b}->{b,~a}
        tgt     = step_dir ? {~ab[0], ab[1]} : {ab[0], ~ab[1]};
        case (state)
            IDLE: begin
                if (step_valid) begin
                    ab_n   = tgt;
                    xfer_n = '{dir: step_dir, mask: ab ^ tgt};
                    cnt_n  = '0;
                    if (bounce_en && BOUNCE_ON) begin
                        state_n = BOUNCE;
                        tog_n   = TOG_INIT;
                    end else begin
                        state_n = SETTLE;
                    end
                end
            end
            BOUNCE: begin
                if (cnt == BOUNCE_LAST) begin
                    ab_n  = ab ^ xfer.mask;
                    cnt_n = '0;
                    tog_n = tog - 1'b1;
                    // even toggle count lands back on the target value
                    if (tog == TOG_W'(1))
                        state_n = SETTLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    pos_n   = xfer.dir ? pos + 8'd1 : pos - 8'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign step_ready = (state == IDLE);
    assign busy       = ~step_ready;
    assign done       = done_q;
    assign enc_a      = ab[1];
    assign enc_b      = ab[0];
    assign position   = pos;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen (default parameters plus
// a BOUNCE_EDGES=0 instance).
module tb_quad_encoder_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       bounce_en = 1'b0;
    logic       step_ready, busy, done, enc_a, enc_b;
    logic [7:0] position;

    logic       v0 = 1'b0;
    logic       d0 = 1'b0;
    logic       b0 = 1'b1;
    logic       rdy0, busy0, done0, a0, bb0;
    logic [7:0] pos0;

    int checks = 0;
    int errors = 0;

    logic ta [0:127];
    logic tbv[0:127];

    always #5 clk = ~clk;

    quad_encoder_gen dut (
        .clk(clk), .reset(reset), .step_valid(step_valid), .step_dir(step_dir),
        .bounce_en(bounce_en), .step_ready(step_ready), .busy(busy), .done(done),
        .enc_a(enc_a), .enc_b(enc_b), .position(position)
    );

    quad_encoder_gen #(.BOUNCE_EDGES(0)) dut0 (
        .clk(clk), .reset(reset), .step_valid(v0), .step_dir(d0),
        .bounce_en(b0), .step_ready(rdy0), .busy(busy0), .done(done0),
        .enc_a(a0), .enc_b(bb0), .position(pos0)
    );

    // Leaves the bench aligned 1 time unit after a posedge.
    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Request already presented; consumes the accepting edge and records the
    // AB trace while step_ready is low. Bounded at 100 cycles.
    task automatic run_xfer(input bit drop_valid, output int low, output int ndone);
        low = 0;
        ndone = 0;
        @(posedge clk); #1;
        if (drop_valid) step_valid = 1'b0;
        while (!step_ready && low < 100) begin
            ta[low]  = enc_a;
            tbv[low] = enc_b;
            if (done) ndone++;
            low++;
            @(posedge clk); #1;
        end
        if (done) ndone++;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({enc_a, enc_b} !== 2'b00) begin errors++; $display("FAIL reset_ab got %b exp 00", {enc_a, enc_b}); end
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", position); end
        checks++; if ({step_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL reset_ctl got %b exp 100", {step_ready, busy, done}); end
        checks++; if ({rdy0, a0, bb0, pos0} !== {1'b1, 2'b00, 8'd0}) begin errors++; $display("FAIL reset_dut0 got %b exp 10000000000", {rdy0, a0, bb0, pos0}); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cw_sequence();
        logic [1:0] exp_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        int low, nd, tot_done, bad;
        tot_done = 0;
        for (int k = 0; k < 4; k++) begin
            step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b0;
            run_xfer(1'b1, low, nd);
            tot_done += nd;
            bad = 0;
            for (int i = 0; i < low; i++)
                if ({ta[i], tbv[i]} !== exp_ab[k]) bad++;
            checks++; if (low !== 16) begin errors++; $display("FAIL cw_low[%0d] got %0d exp 16", k, low); end
            checks++; if ({enc_a, enc_b} !== exp_ab[k]) begin errors++; $display("FAIL cw_ab[%0d] got %b exp %b", k, {enc_a, enc_b}, exp_ab[k]); end
            checks++; if (bad !== 0) begin errors++; $display("FAIL cw_hold[%0d] got %0d bad cycles exp 0", k, bad); end
            checks++; if (position !== 8'(k + 1)) begin errors++; $display("FAIL cw_pos[%0d] got %0d exp %0d", k, position, k + 1); end
        end
        checks++; if (tot_done !== 4) begin errors++; $display("FAIL cw_done got %0d exp 4", tot_done); end
    endtask

    task automatic test_ccw_wrap();
        int low, nd, bad;
        do_reset();
        step_valid = 1'b1; step_dir = 1'b0; bounce_en = 1'b0;
        run_xfer(1'b1, low, nd);
        bad = 0;
        for (int i = 0; i < low; i++) if (ta[i] !== 1'b0) bad++;
        checks++; if ({enc_a, enc_b} !== 2'b01) begin errors++; $display("FAIL ccw_ab got %b exp 01", {enc_a, enc_b}); end
        checks++; if (position !== 8'd255) begin errors++; $display("FAIL ccw_pos got %0d exp 255", position); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ccw_a_moved got %0d exp 0", bad); end
        checks++; if (low !== 16 || nd !== 1) begin errors++; $display("FAIL ccw_timing got low=%0d done=%0d exp 16/1", low, nd); end
    endtask

    task automatic test_bounce();
        int low, nd, bad_a, bad_b;
        logic ea;
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b1;
        run_xfer(1'b1, low, nd);
        bounce_en = 1'b0;
        bad_a = 0; bad_b = 0;
        // A: 1,1,0,0,1,1,0,0,1,1,0,0 then 1 for the 16 settle cycles
        for (int i = 0; i < 28; i++) begin
            ea = (i >= 12) ? 1'b1 : (((i / 2) % 2) == 0);
            if (ta[i] !== ea) bad_a++;
            if (tbv[i] !== 1'b0) bad_b++;
        end
        checks++; if (low !== 28) begin errors++; $display("FAIL bounce_low got %0d exp 28", low); end
        checks++; if (bad_a !== 0) begin errors++; $display("FAIL bounce_a_trace got %0d bad cycles exp 0", bad_a); end
        checks++; if (bad_b !== 0) begin errors++; $display("FAIL bounce_b_still got %0d bad cycles exp 0", bad_b); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL bounce_done got %0d exp 1", nd); end
        checks++; if ({enc_a, enc_b, position} !== {2'b10, 8'd1}) begin errors++; $display("FAIL bounce_end got ab=%b pos=%0d exp 10/1", {enc_a, enc_b}, position); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ab;
        logic [7:0] exp_pos;
        int low, nd;
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_xfer(1'b0, low, nd);
            exp_ab  = (k % 2 == 0) ? 2'b10 : 2'b00;
            exp_pos = (k % 2 == 0) ? 8'd1 : 8'd0;
            checks++; if (low !== 16) begin errors++; $display("FAIL b2b_low[%0d] got %0d exp 16", k, low); end
            checks++; if (nd !== 1) begin errors++; $display("FAIL b2b_done[%0d] got %0d exp 1", k, nd); end
            checks++; if ({enc_a, enc_b} !== exp_ab) begin errors++; $display("FAIL b2b_ab[%0d] got %b exp %b", k, {enc_a, enc_b}, exp_ab); end
            checks++; if (position !== exp_pos) begin errors++; $display("FAIL b2b_pos[%0d] got %0d exp %0d", k, position, exp_pos); end
            step_dir = ~step_dir;
        end
        step_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid_bounce();
        int low, nd, stray;
        do_reset();
        step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0; bounce_en = 1'b0;
        stray = 0;
        repeat (4) begin @(posedge clk); #1; if (done) stray++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b exp 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({enc_a, enc_b} !== 2'b00) begin errors++; $display("FAIL midrst_ab got %b exp 00", {enc_a, enc_b}); end
        checks++; if ({step_ready, busy, done, position} !== {3'b100, 8'd0}) begin errors++; $display("FAIL midrst_ctl got %b exp 10000000000", {step_ready, busy, done, position}); end
        @(negedge clk); reset = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (done) stray++; end
        checks++; if (stray !== 0 || position !== 8'd0) begin errors++; $display("FAIL midrst_nodone got done=%0d pos=%0d exp 0/0", stray, position); end
        step_valid = 1'b1; step_dir = 1'b1;
        run_xfer(1'b1, low, nd);
        checks++; if ({low, nd} !== {32'd16, 32'd1}) begin errors++; $display("FAIL midrst_next got low=%0d done=%0d exp 16/1", low, nd); end
        checks++; if ({enc_a, enc_b, position} !== {2'b10, 8'd1}) begin errors++; $display("FAIL midrst_next_state got ab=%b pos=%0d exp 10/1", {enc_a, enc_b}, position); end
    endtask

    task automatic test_no_bounce_param();
        int low, nd;
        do_reset();
        v0 = 1'b1; d0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        low = 0; nd = 0;
        while (!rdy0 && low < 100) begin
            if (done0) nd++;
            low++;
            @(posedge clk); #1;
        end
        if (done0) nd++;
        checks++; if (low !== 16) begin errors++; $display("FAIL nobounce_low got %0d exp 16", low); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL nobounce_done got %0d exp 1", nd); end
        checks++; if ({a0, bb0, pos0} !== {2'b10, 8'd1}) begin errors++; $display("FAIL nobounce_state got ab=%b pos=%0d exp 10/1", {a0, bb0}, pos0); end
    endtask

    initial begin
        test_reset();
        test_cw_sequence();
        test_ccw_wrap();
        test_bounce();
        test_back_to_back();
        test_reset_mid_bounce();
        test_no_bounce_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_encoder_gen.md
QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 Parameter PHASE_CYCLES, default 16, cycles the new quadrature state is held clean after any bounce; SHALL be >= 1.
REQ-002 Parameter BOUNCE_EDGES, default 3, number of bounce pulse pairs injected per transition when bounce is enabled; 0 SHALL behave as bounce disabled.
REQ-003 Parameter BOUNCE_CYCLES, default 2, cycles between successive bounce toggles; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 step_valid  input  1  request for one quadrature transition.
REQ-007 step_dir  input  1  direction: 1 = CW, 0 = CCW.
REQ-008 bounce_en  input  1  1 = inject contact bounce on this transition.
REQ-009 step_ready  output  1  high when a request can be accepted.
REQ-010 busy  output  1  high while a transition is in progress.
REQ-011 done  output  1  one-cycle pulse when a transition completes.
REQ-012 enc_a  output  1  quadrature phase A, registered.
REQ-013 enc_b  output  1  quadrature phase B, registered.
REQ-014 position  output  8  count of completed transitions, two's-complement, wrapping.

Function
REQ-015 The block SHALL implement states IDLE, BOUNCE and SETTLE.
REQ-016 step_ready SHALL be 1 exactly when in IDLE; busy SHALL equal NOT step_ready.
REQ-017 A request SHALL be accepted on a posedge where step_valid=1 and step_ready=1; step_dir and bounce_en SHALL be sampled only at acceptance.
REQ-018 step_valid while busy SHALL be ignored; there is no queue, and the requester holds step_valid until acceptance.
REQ-019 The CW Gray sequence of {enc_a,enc_b} SHALL be 00->10->11->01->00; CCW SHALL be the exact reverse.
REQ-020 Exactly one of enc_a/enc_b (the "moving line") SHALL change per transition; the other SHALL remain constant for the whole transition.
REQ-021 On acceptance, the moving line SHALL take its target value in the cycle after the accepting edge.
REQ-022 If bounce is active (bounce_en=1 and BOUNCE_EDGES>0), the FSM SHALL enter BOUNCE and toggle the moving line 2*BOUNCE_EDGES times, once every BOUNCE_CYCLES cycles, ending at the target value; otherwise it SHALL enter SETTLE directly.
REQ-023 SETTLE SHALL hold the target state for PHASE_CYCLES cycles, then return to IDLE.
REQ-024 step_ready SHALL be low for exactly PHASE_CYCLES cycles without bounce, and for 2*BOUNCE_EDGES*BOUNCE_CYCLES + PHASE_CYCLES cycles with bounce.
REQ-025 done SHALL pulse for one cycle, coincident with the first cycle step_ready returns high.
REQ-026 position SHALL update in that same cycle: +1 for CW, -1 for CCW, modulo 256 (255+1=0, 0-1=255).
REQ-027 A request accepted in the cycle step_ready returns high SHALL be serviced back-to-back with no idle gap.
REQ-028 Internal counters SHALL be sized from the parameters and SHALL never wrap within a transition.

Reset
REQ-029 Asserting reset SHALL immediately, regardless of clock, force the IDLE state, {enc_a,enc_b}=00, position=0, done=0, busy=0 and step_ready=1.
REQ-030 Reset asserted mid-transition SHALL abandon the transition without updating position or pulsing done.
REQ-031 After reset deasserts, the first accepted request SHALL start from Gray state 00.

Verification
REQ-032 Defaults, bounce_en=0, four CW requests -> AB = 10, 11, 01, 00; each step_ready low for 16 cycles; position = 4; four done pulses.
REQ-033 From 00, one CCW request -> AB = 01, position = 255 (wrap), only enc_b changes.
REQ-034 bounce_en=1, one CW request -> enc_a toggles 1,0,1,0,1,0,1 at 2-cycle spacing, enc_b stays 0, step_ready low for 12+16=28 cycles, done once.
REQ-035 step_valid held high continuously with alternating step_dir -> back-to-back transitions with no gap; requests during busy are ignored; position returns to 0 after each CW/CCW pair.
REQ-036 Reset pulsed mid-BOUNCE -> AB=00, position unchanged at 0, no done pulse; the next request completes normally.
REQ-037 Parameters BOUNCE_EDGES=0 with bounce_en=1 -> timing identical to REQ-032.
